// File: rtl/pio_in_capture.sv
// -----------------------------------------------------------------------------
// pio_in_capture
//
// Avalon-MM slave input PIO. External inputs (buttons / switches) are brought
// into the clk domain through a 2-flop synchronizer. The result is optionally
// debounced to give `filt`. Edges on `filt` are latched per bit into a
// software-clearable edge-capture register. A maskable, active-high level
// interrupt is raised from the captured edges.
//
// Register map (word address, unused upper bits read 0):
//   0 DATA          RO    filtered input value; writes ignored
//   1 reserved      RO    reads 0; writes ignored
//   2 IRQ_MASK      RW    WIDTH bits
//   3 EDGE_CAPTURE  W1C   write 1 to clear a bit; a new edge in the same
//                         cycle wins and the bit stays set
//
// Bus handshake: there is no waitrequest. A write is accepted when
// chipselect & ~write_n and takes effect at the next clk edge. A read is
// accepted when chipselect & ~read_n, and readdata is loaded at the next edge
// (read latency 1). readdata holds its value between reads.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register select (2 bits)
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   in_port     WIDTH asynchronous external inputs
//   readdata    32-bit registered read data
//   irq         level interrupt, |(edge_capture & irq_mask)
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   EDGE_TYPE        0 = rising, 1 = falling, 2 = any edge
//   DEBOUNCE_CYCLES  stable-sample count for the debounce filter (>= 2)
//
// Optional feature: define PIO_IN_DEBOUNCE_EN to add a per-bit debounce
// counter between the synchronizer and `filt`. Without it, `filt` is the
// synchronizer output and DEBOUNCE_CYCLES is ignored.
// -----------------------------------------------------------------------------
module pio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] w1c_bits;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;

    // Only the low WIDTH bits of writedata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // 2-flop synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0] db_cnt [WIDTH];

    // Each bit counts consecutive cycles in which the synchronized input
    // disagrees with the filtered value. Any agreement restarts the count, so
    // a pulse shorter than DEBOUNCE_CYCLES never reaches `filt`.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] != filt[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        filt[i]   <= sync[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign filt = sync;
`endif

    // `prev` resets to 0 together with `filt`, so reset itself never looks
    // like an edge. An input already high at release shows up as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= filt;
        end
    end

    always_comb begin
        edge_det = filt & ~prev;
        if (EDGE_TYPE == 1) begin
            edge_det = ~filt & prev;
        end else if (EDGE_TYPE == 2) begin
            edge_det = filt ^ prev;
        end
    end

    assign w1c_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Clear first, then OR in new edges so an edge in the same cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~w1c_bits) | edge_det;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = filt;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    // Decoded straight from registers; reset clears them asynchronously, so
    // irq drops as soon as reset asserts.
    assign irq = |(edge_capture & irq_mask);

endmodule

// File: doc/pio_in_capture.md
Name: pio_in_capture

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the board's output (LED) PIO.
- Samples external inputs (push-buttons / slide switches) through a 2-flop synchronizer.
- Latches edges per bit into a software-clearable edge-capture register and raises a maskable level interrupt.
- Sits on the Qsys system interconnect beside the output PIOs; Nios II software polls it or takes its IRQ.

Parameters:
- WIDTH, 8: number of input bits (1..32).
- EDGE_TYPE, 0: edge captured; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: stable-sample count required by the debounce filter (used only with PIO_IN_DEBOUNCE_EN; >=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- read_n  input  1  active-low read strobe.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data, read latency 1.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-high. Reset clears all registers: sync stages, filtered value, previous-sample register, edge_capture, irq_mask, readdata. irq = 0 during and after reset.
- Synchronizer: in_port passes through 2 flops to give `sync`.
- Filtered value `filt`:
  - Without the debounce option, `filt` = `sync`.
  - Total latency from an in_port change to `filt`: 2 clk without debounce.
- Edge detect:
  - `prev` <= `filt` every cycle.
  - rise = filt & ~prev; fall = ~filt & prev; edge selected by EDGE_TYPE.
- edge_capture[i]:
  - Sets the cycle after edge[i] is detected.
  - Holds until software clears it.
- Register map (unused upper bits read 0):
  - 0 DATA: RO, returns `filt`; writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: RW, WIDTH bits.
  - 3 EDGE_CAPTURE: RO/W1C; write clears bits where writedata[i] = 1.
- Write: accepted when chipselect & ~write_n; takes effect at the next clk edge.
- Read:
  - When chipselect & ~read_n, readdata is loaded at the next edge with the selected register, zero-extended.
  - Otherwise readdata holds its value.
- Simultaneous W1C and new edge on the same bit in one cycle: the edge wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), decoded from registers with no extra latency.
  - Writing the mask takes effect on irq 1 cycle later.
- A mid-operation reset aborts any debounce count and drops irq immediately (asynchronously).
- Reset does not generate a capture: `prev` and `filt` both reset to 0.
- Because of that, an input already high when reset releases gives a rising edge once it propagates to `filt`. This is intended.

Optional Feature:
- Macro PIO_IN_DEBOUNCE_EN.
- When defined, each bit gets its own counter, $clog2(DEBOUNCE_CYCLES) bits wide:
  - If sync[i] != filt[i], the counter increments.
  - If they match, the counter resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, filt[i] <= sync[i] and the counter resets.
  - Latency from a stable in_port change to `filt` = 2 + DEBOUNCE_CYCLES clk.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- When undefined: there are no counters, `filt` = `sync`, and DEBOUNCE_CYCLES is ignored.

Test Plan:
1. Read DATA after reset:
   - Reset, then hold in_port=8'hA5 for 20 clk, then read address 0.
   - Required: readdata=32'h000000A5 one cycle after the strobe.
   - Before that, edge_capture reads 32'h000000A5 (EDGE_TYPE=0).
2. W1C and IRQ:
   - Write IRQ_MASK=8'h01, pulse in_port[0] 0→1.
   - Required: irq=1 within 3 clk of `filt` rising.
   - Then write EDGE_CAPTURE=32'h1: required irq=0 the next cycle and EDGE_CAPTURE reads 0.
3. Edge wins over clear:
   - Write EDGE_CAPTURE=32'h2 in the same cycle that edge[1] is detected.
   - Required: bit 1 remains 1 and reads 32'h2.
4. Falling-edge variant:
   - EDGE_TYPE=1, in_port[3] 1→0.
   - Required: EDGE_CAPTURE=32'h8.
   - A 0→1 transition leaves it at 0.
5. Debounce (PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
   - A 10-clk high glitch on in_port[2]: required `filt` unchanged and EDGE_CAPTURE=0.
   - A 20-clk high: required DATA bit 2 = 1 at exactly 18 clk after the change.
6. Reset mid-operation:
   - Assert reset while irq=1 and a debounce count is active.
   - Required: irq=0 and readdata=0 immediately.
   - Required: all registers read 0 after release with in_port=0.
